// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: one-shot FSM states and
// debounce-length defaults for simulation and for the 50 MHz board build.
package btn_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_HOLD  = 2'd2,
      S_RSVD  = 2'd3
   } state_t;

   localparam int NUM_BTN_DEFAULT = 3;
   localparam int DEBOUNCE_SIM    = 4;
   localparam int DEBOUNCE_BOARD  = 500000;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, counting debouncer and a one-shot
// FSM that turns each accepted press into a single-cycle pulse.
// btn_n is active-low; held/pulse are active-high and registered.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
)(
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic pulse,
   output logic held
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_count;
   logic          r_debN;
   logic          r_debNDly;
   state_t        r_state;
   state_t        w_stateNext;
   logic          r_pulse;
   logic          r_held;
   logic          w_pulseNext;
   logic          w_heldNext;
   logic          w_pressed;
   logic          w_releaseEdge;

   // Bring the asynchronous button into the clock domain; only r_sync2 is used.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= btn_n;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after it has differed from the debounced value for
   // DEBOUNCE_CYCLES consecutive clocks; any bounce back restarts the count.
   // r_debNDly lets the FSM see the clock in which a release was accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count   <= '0;
         r_debN    <= 1'b1;
         r_debNDly <= 1'b1;
      end else begin
         r_debNDly <= r_debN;
         if (r_sync2 == r_debN) begin
            r_count <= '0;
         end else if (r_count == C_LAST) begin
            r_debN  <= r_sync2;
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign w_pressed     = ~r_debN;
   assign w_releaseEdge = ~r_debNDly & r_debN;

   // Next state and next registered outputs. Leaving S_HOLD normally needs only
   // a released level, but after reset (held still 0) it waits for an actual
   // accepted release, so a button held through reset cannot produce a pulse.
   always_comb begin
      w_stateNext = r_state;
      w_pulseNext = 1'b0;
      w_heldNext  = r_held;
      case (r_state)
         S_IDLE: begin
            if (w_pressed) begin
               w_stateNext = S_PULSE;
            end
         end
         S_PULSE: begin
            w_stateNext = S_HOLD;
         end
         S_HOLD: begin
            if (r_held ? !w_pressed : w_releaseEdge) begin
               w_stateNext = S_IDLE;
            end
         end
         default: begin
            w_stateNext = S_HOLD;
         end
      endcase
      if (w_stateNext == S_PULSE) begin
         w_pulseNext = 1'b1;
         w_heldNext  = 1'b1;
      end else if (w_stateNext == S_IDLE) begin
         w_heldNext  = 1'b0;
      end
   end

   // State register with registered pulse/held outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_HOLD;
         r_pulse <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_pulse <= w_pulseNext;
         r_held  <= w_heldNext;
      end
   end

   assign pulse = r_pulse;
   assign held  = r_held;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NUM_BTN raw active-low pushbuttons into clean one-cycle press
// pulses plus debounced held levels; channels are fully independent.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int NUM_BTN         = NUM_BTN_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_n,
   output logic [NUM_BTN-1:0] pulse,
   output logic [NUM_BTN-1:0] held
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .btn_n (btn_n[g]),
         .pulse (pulse[g]),
         .held  (held[g])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner. A reference model samples the buttons
// each clock, decides press/release acceptance from a sliding window of the
// last DEBOUNCE_CYCLES synchronized samples, and queues the expected pulses;
// a monitor compares pulse/held on the falling edge.
module tb_btn_conditioner;

   localparam int NB = 3;
   localparam int DB = 4;

   typedef struct {
      int ch;
      int edgeAt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NB-1:0] btn_n = '1;
   logic [NB-1:0] pulse;
   logic [NB-1:0] held;

   int   edgeNo     = 0;
   int   compared   = 0;
   int   mismatched = 0;
   exp_t expQ[$];

   bit          armed[NB];
   bit          levelRel[NB];
   bit          dly1[NB];
   bit          dly2[NB];
   logic [DB-1:0] hist[NB];
   int          histN[NB];
   bit          heldPend[NB];
   bit          heldExp[NB];

   btn_conditioner #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n),
      .pulse (pulse),
      .held  (held)
   );

   // 20 ns clock.
   always #10 clk = ~clk;

   task automatic checkOutput(input string name, input int ch, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s ch%0d: got %b, expected %b (edge %0d)", name, ch, act, exp, edgeNo);
      end
   endtask

   task automatic applyStimulus(input logic [NB-1:0] v, input int n);
      btn_n = v;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyReset(input int n);
      rst = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b1;
   endtask

   // Reference model: two-sample synchronizer delay, then a level is accepted
   // once the last DB samples all show the opposite of the accepted level.
   // Every accepted press yields a pulse except one not preceded by an accepted
   // release since reset; the pulse and held rise are seen one clock later.
   always @(posedge clk) begin
      edgeNo++;
      for (int c = 0; c < NB; c++) begin
         heldExp[c] = heldPend[c];
         if (!rst) begin
            armed[c]    = 1'b0;
            levelRel[c] = 1'b1;
            dly1[c]     = 1'b1;
            dly2[c]     = 1'b1;
            hist[c]     = '0;
            histN[c]    = 0;
            heldPend[c] = 1'b0;
            heldExp[c]  = 1'b0;
         end else begin
            bit eff;
            eff     = dly2[c];
            dly2[c] = dly1[c];
            dly1[c] = btn_n[c];
            hist[c] = {hist[c][DB-2:0], eff};
            if (histN[c] < DB) histN[c]++;
            if (histN[c] >= DB && hist[c] == {DB{~levelRel[c]}}) begin
               levelRel[c] = eff;
               if (!eff) begin
                  if (armed[c]) begin
                     expQ.push_back('{ch: c, edgeAt: edgeNo + 1});
                     heldPend[c] = 1'b1;
                  end
                  armed[c] = 1'b0;
               end else begin
                  armed[c]    = 1'b1;
                  heldPend[c] = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: outputs forced low during reset; otherwise held follows the model
   // and each pulse must match the queued expectation for that channel.
   always @(negedge clk) begin
      if (!rst) begin
         expQ.delete();
         for (int c = 0; c < NB; c++) begin
            checkOutput("resetPulse", c, pulse[c], 1'b0);
            checkOutput("resetHeld", c, held[c], 1'b0);
         end
      end else begin
         for (int c = 0; c < NB; c++) begin
            automatic int idx = -1;
            automatic bit due = 1'b0;
            for (int i = 0; i < expQ.size(); i++) begin
               if (idx < 0 && expQ[i].ch == c) idx = i;
            end
            if (idx >= 0 && expQ[idx].edgeAt <= edgeNo) begin
               due = (expQ[idx].edgeAt == edgeNo);
               if (!due) checkOutput("stalePulse", c, 1'b0, 1'b1);
               expQ.delete(idx);
            end
            checkOutput("pulse", c, pulse[c], due);
            checkOutput("held", c, held[c], heldExp[c]);
         end
      end
   end

   // Directed scenarios followed by randomized button activity.
   initial begin
      rst   = 1'b0;
      btn_n = '1;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b1;

      applyStimulus(3'b111, 5);
      applyStimulus(3'b000, 20);
      applyStimulus(3'b111, 15);

      applyStimulus(3'b110, 20);
      applyStimulus(3'b111, 15);

      applyStimulus(3'b101, 1);
      applyStimulus(3'b111, 1);
      applyStimulus(3'b101, 1);
      applyStimulus(3'b111, 1);
      applyStimulus(3'b101, 15);
      applyStimulus(3'b111, 15);

      applyStimulus(3'b010, 15);
      applyStimulus(3'b111, 15);

      applyStimulus(3'b110, 3);
      applyStimulus(3'b111, 15);

      applyStimulus(3'b110, 4);
      applyReset(3);
      applyStimulus(3'b110, 20);
      applyStimulus(3'b111, 15);
      applyStimulus(3'b110, 15);
      applyStimulus(3'b111, 15);

      applyStimulus(3'b011, 7);
      applyReset(2);
      applyStimulus(3'b111, 15);

      repeat (150) begin
         applyStimulus(NB'($urandom), int'($urandom_range(1, 9)));
      end
      applyStimulus(3'b111, 20);

      while (expQ.size() > 0) begin
         checkOutput("pulseNeverSeen", expQ[0].ch, 1'b0, 1'b1);
         expQ.pop_front();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
